rx_pipeline_sequencer: RTL and testbench

//  Per-sample scheduler for the rx chain: low-pass -> band-pass (decimated) -> correlator -> peak identification.

---
 rtl/rx_pipeline_sequencer.sv | 171 +++++++++++++++++
 tb/tb_rx_pipeline_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_pipeline_sequencer.sv
// rx_pipeline_sequencer
//   Per-sample scheduler for the rx chain: low-pass -> band-pass (decimated)
//   -> correlator (one run per reference sequence) -> peak identification.
//   Each accepted ADC strobe gives one o_lp_en. Every DECIM-th accepted sample
//   also gives o_bp_en. The correlator then runs NUM_SEQ start/done rounds,
//   and one o_peak_en follows.
//
// Optional feature: define RX_SEQ_TIMEOUT_EN to add a done watchdog in WAIT.
//
// Ports
//   crx_clk, rrx_rst    clock, asynchronous active-high reset
//   erx_en              block enable; low aborts the frame and parks in IDLE
//   inew_sample         strobe, new ADC sample
//   i_corr_done         strobe, correlator finished current sequence
//   i_clr_overrun       clears o_overrun / o_timeout_err
//   o_lp_en, o_bp_en    filter consume pulses
//   o_corr_start        correlation start pulse
//   o_corr_seq_sel      current sequence index
//   o_peak_en           peak identification pulse
//   o_timestamp         decimated-sample count, latched at band-pass enable
//   o_busy              FSM not IDLE
//   o_overrun           sticky, strobe arrived while busy
//   o_timeout_err       sticky, correlator done missing (0 without the watchdog)
module rx_pipeline_sequencer #(
  parameter int DECIM   = 4,
  parameter int NUM_SEQ = 4,
  parameter int SEQ_W   = 4,
  parameter int LP_LAT  = 1,
  parameter int TIMEOUT = 24
) (
  input  logic             crx_clk,
  input  logic             rrx_rst,
  input  logic             erx_en,
  input  logic             inew_sample,
  input  logic             i_corr_done,
  input  logic             i_clr_overrun,
  output logic             o_lp_en,
  output logic             o_bp_en,
  output logic             o_corr_start,
  output logic [SEQ_W-1:0] o_corr_seq_sel,
  output logic             o_peak_en,
  output logic [15:0]      o_timestamp,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_timeout_err
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0]    DECIM_LAST = DW'(DECIM - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST   = SEQ_W'(NUM_SEQ - 1);
  localparam logic [3:0]       LAT_LAST   = 4'((LP_LAT == 0) ? 0 : LP_LAT - 1);

  typedef enum logic [2:0] {IDLE, LP, LPWAIT, BP, START, WAIT, PEAK} state_t;

  state_t           state, nxt;
  logic [DW-1:0]    decim_cnt;
  logic [15:0]      ts_cnt;
  logic [SEQ_W-1:0] seq_idx;
  logic [3:0]       lat_cnt;
  logic             decide, adv, tmo;
  logic             last_decim, last_seq;

  assign last_decim = (decim_cnt == DECIM_LAST);
  assign last_seq   = (seq_idx == SEQ_LAST);

`ifdef RX_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;
  logic          tmo_hit;
  assign tmo_hit = (wcnt == TW'(TIMEOUT - 1));
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  // decide: end of LP latency, band-pass/skip decision taken this cycle.
  // adv: correlator round finished (done or watchdog expiry).
  always_comb begin
    nxt    = state;
    decide = 1'b0;
    adv    = 1'b0;
    tmo    = 1'b0;
    case (state)
      IDLE:   if (inew_sample) nxt = LP;
      LP: begin
        if (LP_LAT == 0) begin
          decide = 1'b1;
          nxt    = last_decim ? BP : IDLE;
        end else begin
          nxt = LPWAIT;
        end
      end
      LPWAIT: begin
        if (lat_cnt == LAT_LAST) begin
          decide = 1'b1;
          nxt    = last_decim ? BP : IDLE;
        end
      end
      BP:     nxt = START;
      START:  nxt = WAIT;
      WAIT: begin
        // done on the expiry cycle wins, so no error in that case
        if (i_corr_done) adv = 1'b1;
        else if (tmo_hit) begin
          adv = 1'b1;
          tmo = 1'b1;
        end
        if (adv) nxt = last_seq ? PEAK : START;
      end
      PEAK:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (!erx_en) begin
      nxt    = IDLE;
      decide = 1'b0;
      adv    = 1'b0;
      tmo    = 1'b0;
    end
  end

  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      state       <= IDLE;
      decim_cnt   <= '0;
      ts_cnt      <= '0;
      seq_idx     <= '0;
      lat_cnt     <= '0;
      o_timestamp <= '0;
      o_overrun   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == LP) lat_cnt <= '0;
      else if (state == LPWAIT && erx_en) lat_cnt <= lat_cnt + 4'd1;
      if (decide) decim_cnt <= last_decim ? '0 : decim_cnt + DW'(1);
      if (state == BP && erx_en) begin
        o_timestamp <= ts_cnt;
        ts_cnt      <= ts_cnt + 16'd1;
        seq_idx     <= '0;
      end
      if (adv && !last_seq) seq_idx <= seq_idx + SEQ_W'(1);
      // a new drop event outranks the clear
      if (inew_sample && state != IDLE) o_overrun <= 1'b1;
      else if (i_clr_overrun)           o_overrun <= 1'b0;
    end
  end

`ifdef RX_SEQ_TIMEOUT_EN
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      wcnt          <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      if (state == WAIT) wcnt <= wcnt + TW'(1);
      else               wcnt <= '0;
      if (tmo)                o_timeout_err <= 1'b1;
      else if (i_clr_overrun) o_timeout_err <= 1'b0;
    end
  end
`else
  assign o_timeout_err = 1'b0;
`endif

  // pulses are suppressed in the cycle the block is disabled
  assign o_lp_en        = (state == LP)    && erx_en;
  assign o_bp_en        = (state == BP)    && erx_en;
  assign o_corr_start   = (state == START) && erx_en;
  assign o_peak_en      = (state == PEAK)  && erx_en;
  assign o_corr_seq_sel = seq_idx;
  assign o_busy         = (state != IDLE);

endmodule

// File: tb/tb_rx_pipeline_sequencer.sv
module tb_rx_pipeline_sequencer;

  logic       crx_clk = 1'b0;
  logic       rrx_rst = 1'b1;
  logic       erx_en = 1'b0;
  logic       inew_sample = 1'b0;
  logic       i_corr_done = 1'b0;
  logic       i_clr_overrun = 1'b0;
  logic       o_lp_en, o_bp_en, o_corr_start, o_peak_en;
  logic [3:0] o_corr_seq_sel;
  logic [15:0] o_timestamp;
  logic       o_busy, o_overrun, o_timeout_err;

  rx_pipeline_sequencer dut (
    .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(erx_en),
    .inew_sample(inew_sample), .i_corr_done(i_corr_done),
    .i_clr_overrun(i_clr_overrun), .o_lp_en(o_lp_en), .o_bp_en(o_bp_en),
    .o_corr_start(o_corr_start), .o_corr_seq_sel(o_corr_seq_sel),
    .o_peak_en(o_peak_en), .o_timestamp(o_timestamp), .o_busy(o_busy),
    .o_overrun(o_overrun), .o_timeout_err(o_timeout_err)
  );

  always #5 crx_clk = ~crx_clk;

  int n_cmp = 0, n_err = 0;
  int n_lp = 0, n_bp = 0, n_start = 0, n_peak = 0;
  logic [3:0]  sel_log [64];
  logic [15:0] ts_log  [16];
  logic        pend = 1'b0;
  logic [3:0]  skip_sel = 4'hF;

  // pulse monitor: samples the cycle's outputs at its closing edge
  always @(posedge crx_clk) begin
    if (!rrx_rst) begin
      if (o_lp_en) n_lp++;
      if (o_bp_en) n_bp++;
      if (o_corr_start) begin
        if (n_start < 64) sel_log[n_start] = o_corr_seq_sel;
        n_start++;
      end
      if (o_peak_en) begin
        if (n_peak < 16) ts_log[n_peak] = o_timestamp;
        n_peak++;
      end
    end
  end

  // correlator model: done one cycle after start, except for skip_sel
  always @(negedge crx_clk) begin
    i_corr_done = pend;
    pend = o_corr_start && (o_corr_seq_sel != skip_sel);
  end

  task automatic tick();
    @(negedge crx_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // strobe in the current cycle; returns in the o_lp_en cycle
  task automatic strobe();
    inew_sample = 1'b1;
    tick();
    inew_sample = 1'b0;
  endtask

  task automatic skip_frames(input int n);
    for (int k = 0; k < n; k++) begin
      strobe();
      repeat (8) tick();
    end
  endtask

  int lp0, bp0, st0, pk0;

  initial begin
    repeat (2) tick();
    chk("rst_lp",   o_lp_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ts",   o_timestamp, 0);
    chk("rst_sel",  o_corr_seq_sel, 0);
    chk("rst_ovr",  o_overrun, 0);
    rrx_rst = 1'b0;
    erx_en  = 1'b1;
    tick();

    // eight strobes, one every 128 clocks
    for (int i = 0; i < 8; i++) begin
      strobe();
      repeat (127) tick();
    end
    chk("t1_lp",    n_lp, 8);
    chk("t1_bp",    n_bp, 2);
    chk("t1_start", n_start, 8);
    chk("t1_peak",  n_peak, 2);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_sel%0d", i), sel_log[i], i % 4);
    chk("t1_ts0", ts_log[0], 0);
    chk("t1_ts1", ts_log[1], 1);

    // latency walk of a decimating frame, plus a dropped strobe in WAIT
    skip_frames(3);
    strobe();                                      // c1
    chk("t2_lp_c1", o_lp_en, 1);
    tick();                                        // c2
    chk("t2_busy_c2", o_busy, 1);
    chk("t2_bp_c2", o_bp_en, 0);
    tick();                                        // c3
    chk("t2_bp_c3", o_bp_en, 1);
    tick();                                        // c4
    chk("t2_start_c4", o_corr_start, 1);
    chk("t2_sel_c4", o_corr_seq_sel, 0);
    chk("t2_ts", o_timestamp, 2);
    tick();                                        // c5
    lp0 = n_lp;
    strobe();                                      // c6
    chk("t2_ovr", o_overrun, 1);
    repeat (6) tick();                             // c12
    chk("t2_peak_c12", o_peak_en, 1);
    tick();
    chk("t2_drop_lp", n_lp, lp0);
    chk("t2_busy_end", o_busy, 0);
    i_clr_overrun = 1'b1;
    tick();
    i_clr_overrun = 1'b0;
    chk("t2_clr", o_overrun, 0);
    repeat (4) tick();

    // disable during WAIT of seq 2
    skip_frames(3);
    st0 = n_start;
    pk0 = n_peak;
    strobe();                                      // c1
    repeat (8) tick();                             // c9
    chk("t3_sel_wait2", o_corr_seq_sel, 2);
    erx_en = 1'b0;
    tick();
    chk("t3_idle", o_busy, 0);
    repeat (20) tick();
    chk("t3_no_peak", n_peak, pk0);
    chk("t3_starts", n_start, st0 + 3);
    erx_en = 1'b1;
    bp0 = n_bp;
    skip_frames(3);
    chk("t3_decim_held", n_bp, bp0);
    strobe();
    repeat (3) tick();                             // c4
    chk("t3_restart_sel", o_corr_seq_sel, 0);
    chk("t3_restart_go", o_corr_start, 1);
    chk("t3_ts", o_timestamp, 4);
    repeat (10) tick();
    chk("t3_peak", n_peak, pk0 + 1);

`ifdef RX_SEQ_TIMEOUT_EN
    // withhold done for sequence 1
    skip_sel = 4'd1;
    skip_frames(3);
    pk0 = n_peak;
    strobe();
    repeat (29) tick();                            // c30, 24th WAIT cycle
    chk("t4_no_err_yet", o_timeout_err, 0);
    tick();                                        // c31
    chk("t4_err", o_timeout_err, 1);
    chk("t4_start2", o_corr_start, 1);
    chk("t4_sel2", o_corr_seq_sel, 2);
    repeat (4) tick();                             // c35
    chk("t4_peak", o_peak_en, 1);
    skip_sel = 4'hF;
    i_clr_overrun = 1'b1;
    tick();
    i_clr_overrun = 1'b0;
    chk("t4_clr", o_timeout_err, 0);
`else
    chk("t4_tmo_tied", o_timeout_err, 0);
`endif
    repeat (4) tick();

    // asynchronous reset in START
    skip_frames(3);
    strobe();
    repeat (3) tick();                             // c4
    chk("t5_in_start", o_corr_start, 1);
    #2 rrx_rst = 1'b1;
    #1;
    chk("t5_start0", o_corr_start, 0);
    chk("t5_busy0", o_busy, 0);
    chk("t5_ts0", o_timestamp, 0);
    chk("t5_sel0", o_corr_seq_sel, 0);
    #1 rrx_rst = 1'b0;
    tick();
    strobe();
    chk("t5_lp_after", o_lp_en, 1);
    repeat (2) tick();
    chk("t5_no_bp", o_bp_en, 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
